pipe_reduce_tree: RTL and testbench
===================================

// Module: pipe_reduce_tree
// PURPOSE
//  Parametrised, fully pipelined signed reduction tree with valid/ready flow control,
//  lossless width growth, an optional multi-beat accumulate mode and optional output
//  saturation. Sums one N-element vector per accepted beat. Sits behind the MAC
//  arrays of the inference datapath and produces dot-product partial or final sums.
// PARAMETERS
//  N        12  number of elements per vector (>=1)
//  IW        8  signed width of each input element
//  OW        8  signed width of out_data
//  ACCUM     0  1 = accumulate tree sums across beats until in_last
//  ACC_BITS  8  extra accumulator headroom bits (ACCUM=1 only)
//  SAT       1  1 = clamp to OW range; 0 = keep low OW bits (two's-complement wrap)
// PORTS
//  clk_in     in   1       clock, all state on rising edge
//  rst_n_in   in   1       asynchronous active-low reset
//  in_valid   in   1       in_data/in_last valid
//  in_ready   out  1       block can accept a beat this cycle
//  in_data    in   N*IW    packed [N-1:0][IW-1:0], each element signed
//  in_last    in   1       last beat of an accumulation group (ignored if ACCUM=0)
//  out_valid  out  1       out_data valid
//  out_ready  in   1       downstream accepts out_data
//  out_data   out  OW      signed result
//  out_sat    out  1       result was clamped (SAT=1) or wrapped (SAT=0) this output
// BEHAVIOUR
//  - One clock; reset asynchronous, active-low. On reset: all stage valids, accumulator,
//    out_valid, out_data, out_sat = 0. in_ready = 1 one cycle after reset deassertion.
//  - Global advance: en = !out_valid | out_ready; in_ready = en. Beat accepted when
//    in_valid & in_ready. When en=0 every pipeline register holds (no bubbles collapse).
//  - LEVELS = max(1, $clog2(N)). Level k (1..LEVELS) is one register stage, width
//    IW+k; pairs summed with sign extension; odd leftover element sign-extended and
//    passed through registered. Tree sum TW = IW+$clog2(N) bits, never overflows.
//  - A valid bit travels with each stage; invalid stages still advance on en.
//  - Output stage (1 register):
//    ACCUM=0: out_data = fit(sum); one output per accepted beat.
//    ACCUM=1: acc (TW+ACC_BITS bits) += sum on each valid beat; on the beat carrying
//      in_last, out_data = fit(acc + sum), out_valid = 1, acc cleared to 0 in the same
//      edge. Non-last beats produce no output. Acc wraps silently at its width.
//  - fit(x): SAT=1 -> clamp to [-2^(OW-1), 2^(OW-1)-1], out_sat = 1 if clamped;
//    SAT=0 -> x[OW-1:0], out_sat = 1 if bits above OW-1 are not the sign extension.
//    If OW >= source width, value is sign-extended and out_sat = 0.
//  - Latency: LEVELS+1 advancing cycles from acceptance to out_valid (N=12: 5).
//    Throughput 1 beat/cycle when out_ready held high.
//  - out_valid held with stable out_data/out_sat until out_ready.
//  - in_last travels the pipeline with its beat; back-to-back groups need no idle.
//  - Reset mid-operation discards all in-flight beats and partial accumulation.
// STRUCTURE
//  - bespoke_pkg: function sat_fit(), localparam helper for tree width (IW+$clog2(N)).
//  - Sub-module reduce_level #(.IN_N, .W): one registered level, ceil(IN_N/2) outputs of
//    W+1 bits, carries valid/last, honours en. Top generate-loops LEVELS instances
//    (no recursion), then the accumulate/fit output stage.
// TESTING
//  1. N=12 IW=8 OW=8 SAT=1: all elems 127 -> out_data 127, out_sat 1 (raw 1524);
//     all -128 -> -128, out_sat 1; elems 1..12 -> 78, out_sat 0; latency exactly 5.
//  2. OW=12 SAT=0: all 127 -> 1524, out_sat 0; OW=8 SAT=0 same input -> 0xF4 (-12),
//     out_sat 1.
//  3. ACCUM=1 OW=16: beats of all-1s, all-2s, all-3s (last on 3rd) -> single output 72;
//     immediately following group all-(-1) x2 -> -24 (acc cleared between groups).
//  4. Backpressure: stream 20 beats, out_ready random 50%: every result appears once,
//     in order, unchanged while stalled; in_ready low whenever out_valid & !out_ready.
//  5. Reset asserted mid-stream with 3 beats in flight and partial acc: out_valid
//     drops asynchronously, no stale output after release; next group sums from 0.
//  6. Edge sizes N=1 (latency 2, passthrough) and N=3, N=5 odd trees: randomised
//     vectors vs. reference model, 1000 beats each.

Source files
------------

// File: rtl/pipe_reduce_tree_pkg.sv
// Shared helpers for the pipelined reduction tree:
// tree geometry and the output fit (clamp or wrap) functions.
package pipe_reduce_tree_pkg;

    // Fit functions operate on a wide signed value; sources are sign-extended into it.
    localparam int FIT_W = 64;

    // Lossless width of the full tree sum.
    function automatic int tree_w(input int iw, input int n);
        return iw + $clog2(n);
    endfunction

    // Number of register levels in the tree (at least one, also for n=1).
    function automatic int tree_levels(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of elements entering level k (1-based).
    function automatic int level_n(input int n, input int k);
        return (n + (1 << (k - 1)) - 1) >> (k - 1);
    endfunction

    // Fitted value: clamp (sat=1) or two's-complement wrap (sat=0) to ow bits.
    function automatic logic signed [FIT_W-1:0] sat_fit(
        input logic signed [FIT_W-1:0] x,
        input int                      ow,
        input int                      src_w,
        input logic                    sat
    );
        logic signed [FIT_W-1:0] hi;
        logic signed [FIT_W-1:0] lo;
        logic signed [FIT_W-1:0] wr;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = ~hi;
        wr = (x <<< (FIT_W - ow)) >>> (FIT_W - ow);
        if (ow >= src_w) return x;
        if (!sat)        return wr;
        if (x > hi)      return hi;
        if (x < lo)      return lo;
        return x;
    endfunction

    // Flag raised when the fitted value differs from the source value.
    function automatic logic sat_flag(
        input logic signed [FIT_W-1:0] x,
        input int                      ow,
        input int                      src_w,
        input logic                    sat
    );
        logic signed [FIT_W-1:0] hi;
        logic signed [FIT_W-1:0] lo;
        logic signed [FIT_W-1:0] wr;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = ~hi;
        wr = (x <<< (FIT_W - ow)) >>> (FIT_W - ow);
        if (ow >= src_w) return 1'b0;
        if (!sat)        return wr != x;
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/pipe_reduce_tree_level.sv
// One registered level of the reduction tree.
// Ports: clk/rst_n, en (global advance), in_valid/in_last/in_data (IN_N x W),
// out_valid/out_last/out_data (ceil(IN_N/2) x W+1).
module reduce_level #(
    parameter int IN_N = 2,
    parameter int W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [IN_N-1:0][W-1:0]       in_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [(IN_N+1)/2-1:0][W:0]   out_data
);

    localparam int OUT_N = (IN_N + 1) / 2;

    logic [OUT_N-1:0][W:0] pair_sum;
    logic [OUT_N-1:0][W:0] data_d;
    logic [OUT_N-1:0][W:0] data_q;
    logic                  valid_d;
    logic                  valid_q;
    logic                  last_d;
    logic                  last_q;

    for (genvar i = 0; i < OUT_N; i++) begin : g_pair
        if (2 * i + 1 < IN_N) begin : g_add
            assign pair_sum[i] = {in_data[2*i][W-1], in_data[2*i]}
                               + {in_data[2*i+1][W-1], in_data[2*i+1]};
        end else begin : g_pass
            // Odd leftover element: sign-extend and register unchanged.
            assign pair_sum[i] = {in_data[2*i][W-1], in_data[2*i]};
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (en) begin
            data_d  = pair_sum;
            valid_d = in_valid;
            last_d  = in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: rtl/pipe_reduce_tree.sv
// Pipelined signed reduction tree with valid/ready, optional accumulate, clamp/wrap.
// Ports: clk_in, rst_n_in, in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_data/out_sat.
module pipe_reduce_tree
    import pipe_reduce_tree_pkg::*;
#(
    parameter int N        = 12,
    parameter int IW       = 8,
    parameter int OW       = 8,
    parameter int ACCUM    = 0,
    parameter int ACC_BITS = 8,
    parameter int SAT      = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0][IW-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_data,
    output logic                 out_sat
);

    localparam int LEVELS = tree_levels(N);
    localparam int TW     = tree_w(IW, N);
    localparam int SW     = IW + LEVELS;
    localparam int AW     = TW + ACC_BITS;

    logic                 en;
    logic                 fin_valid;
    logic                 fin_last;
    logic signed [SW-1:0] sum;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_q;
    logic                 out_valid_d;
    logic                 out_valid_q;
    logic [OW-1:0]        out_data_d;
    logic [OW-1:0]        out_data_q;
    logic                 out_sat_d;
    logic                 out_sat_q;

    // Every register advances together; a stalled output freezes the whole pipe.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int LN = level_n(N, k);
        localparam int LW = IW + k - 1;

        logic [LN-1:0][LW-1:0]       din;
        logic                        vin;
        logic                        lin;
        logic [(LN+1)/2-1:0][LW:0]   dout;
        logic                        vout;
        logic                        lout;

        if (k == 1) begin : g_first
            assign din = in_data;
            assign vin = in_valid;
            assign lin = in_last;
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
            assign lin = g_lvl[k-1].lout;
        end

        reduce_level #(
            .IN_N (LN),
            .W    (LW)
        ) u_level (
            .clk       (clk_in),
            .rst_n     (rst_n_in),
            .en        (en),
            .in_valid  (vin),
            .in_last   (lin),
            .in_data   (din),
            .out_valid (vout),
            .out_last  (lout),
            .out_data  (dout)
        );
    end

    assign sum       = g_lvl[LEVELS].dout[0];
    assign fin_valid = g_lvl[LEVELS].vout;
    assign fin_last  = g_lvl[LEVELS].lout;
    assign acc_sum   = acc_q + AW'(sum);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        acc_d       = acc_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (fin_valid) begin
                if (ACCUM == 0) begin
                    out_valid_d = 1'b1;
                    out_data_d  = OW'(sat_fit(FIT_W'(sum), OW, TW, SAT != 0));
                    out_sat_d   = sat_flag(FIT_W'(sum), OW, TW, SAT != 0);
                end else if (fin_last) begin
                    // Close the group and restart the accumulator on the same edge.
                    out_valid_d = 1'b1;
                    out_data_d  = OW'(sat_fit(FIT_W'(acc_sum), OW, AW, SAT != 0));
                    out_sat_d   = sat_flag(FIT_W'(acc_sum), OW, AW, SAT != 0);
                    acc_d       = '0;
                end else begin
                    acc_d = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pipe_reduce_tree.sv
// Scoreboard bench for pipe_reduce_tree: several parameterisations,
// directed vectors, backpressure, reset mid-stream and odd tree sizes.
`define MON(BLK, Q, OV, ORDY, OD, OS, NM) \
    always @(negedge clk) begin : BLK \
        exp_t e_; \
        if (rst_n && OV && ORDY) begin \
            if (Q.size() == 0) begin \
                tfail({NM, " extra output"}); \
            end else begin \
                e_ = Q.pop_front(); \
                chk({NM, " data"}, int'($signed(OD)), e_.d); \
                chk({NM, " sat"}, int'(OS), int'(e_.s)); \
            end \
        end \
    end

module tb_pipe_reduce_tree;

    typedef struct {
        int d;
        bit s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        vin = 1'b0;
    logic        lin = 1'b0;
    logic [95:0] din = '0;
    logic        or_force = 1'b1;
    logic        rnd_or = 1'b0;
    logic        or0 = 1'b1;
    logic        en1 = 1'b1;
    logic        v1;
    logic        v2;

    logic        rdy0, ov0, os0;
    logic [7:0]  od0;
    logic        rdy1, ov1, os1;
    logic [7:0]  od1;
    logic        rdy2, ov2, os2;
    logic [15:0] od2;

    logic        vs = 1'b0;
    logic [95:0] ds = '0;
    logic        rdy3, ov3, os3;
    logic [7:0]  od3;
    logic        rdy4, ov4, os4;
    logic [5:0]  od4;
    logic        rdy5, ov5, os5;
    logic [8:0]  od5;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t q4[$];
    exp_t q5[$];

    assign v1 = vin & rdy0 & en1;
    assign v2 = vin & rdy0;

    pipe_reduce_tree #(.N(12), .IW(8), .OW(8), .ACCUM(0), .ACC_BITS(8), .SAT(1)) u_d0 (
        .clk_in(clk), .rst_n_in(rst_n), .in_valid(vin), .in_ready(rdy0),
        .in_data(din), .in_last(lin), .out_valid(ov0), .out_ready(or0),
        .out_data(od0), .out_sat(os0));

    pipe_reduce_tree #(.N(12), .IW(8), .OW(8), .ACCUM(0), .ACC_BITS(8), .SAT(0)) u_d1 (
        .clk_in(clk), .rst_n_in(rst_n), .in_valid(v1), .in_ready(rdy1),
        .in_data(din), .in_last(lin), .out_valid(ov1), .out_ready(1'b1),
        .out_data(od1), .out_sat(os1));

    pipe_reduce_tree #(.N(12), .IW(8), .OW(16), .ACCUM(1), .ACC_BITS(8), .SAT(1)) u_d2 (
        .clk_in(clk), .rst_n_in(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_data(din), .in_last(lin), .out_valid(ov2), .out_ready(1'b1),
        .out_data(od2), .out_sat(os2));

    pipe_reduce_tree #(.N(3), .IW(8), .OW(8), .ACCUM(0), .ACC_BITS(8), .SAT(0)) u_d3 (
        .clk_in(clk), .rst_n_in(rst_n), .in_valid(vs), .in_ready(rdy3),
        .in_data(ds[23:0]), .in_last(1'b0), .out_valid(ov3), .out_ready(1'b1),
        .out_data(od3), .out_sat(os3));

    pipe_reduce_tree #(.N(1), .IW(8), .OW(6), .ACCUM(0), .ACC_BITS(8), .SAT(1)) u_d4 (
        .clk_in(clk), .rst_n_in(rst_n), .in_valid(vs), .in_ready(rdy4),
        .in_data(ds[7:0]), .in_last(1'b0), .out_valid(ov4), .out_ready(1'b1),
        .out_data(od4), .out_sat(os4));

    pipe_reduce_tree #(.N(5), .IW(8), .OW(9), .ACCUM(0), .ACC_BITS(8), .SAT(1)) u_d5 (
        .clk_in(clk), .rst_n_in(rst_n), .in_valid(vs), .in_ready(rdy5),
        .in_data(ds[39:0]), .in_last(1'b0), .out_valid(ov5), .out_ready(1'b1),
        .out_data(od5), .out_sat(os5));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tfail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    function automatic exp_t mk(input int d, input bit s);
        exp_t e;
        e.d = d;
        e.s = s;
        return e;
    endfunction

    // Reference fit: clamp or two's-complement wrap to ow bits.
    function automatic exp_t fitm(input int x, input int ow, input bit sat);
        exp_t e;
        int hi;
        int lo;
        int w;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        if (sat) begin
            e.d = (x > hi) ? hi : ((x < lo) ? lo : x);
            e.s = (x > hi) || (x < lo);
        end else begin
            w = x & ((1 << ow) - 1);
            if (w > hi) w -= (1 << ow);
            e.d = w;
            e.s = (w != x);
        end
        return e;
    endfunction

    function automatic logic [95:0] fill(input int x);
        logic [95:0] v;
        for (int j = 0; j < 12; j++) v[j*8 +: 8] = 8'(x);
        return v;
    endfunction

    function automatic int vsum(input logic [95:0] v, input int n);
        int s;
        s = 0;
        for (int j = 0; j < n; j++) s += int'($signed(v[j*8 +: 8]));
        return s;
    endfunction

    // Random out_ready for the main DUT, applied shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        or0 = rnd_or ? 1'($urandom_range(0, 1)) : or_force;
    end

    // Held output must stay put while stalled; in_ready must drop on a stall.
    logic [7:0] prev_d;
    logic       prev_s;
    logic       stalled = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold valid", int'(ov0), 1);
                chk("hold data", int'(od0), int'(prev_d));
                chk("hold sat", int'(os0), int'(prev_s));
            end
            if (ov0 && !or0) chk("in_ready on stall", int'(rdy0), 0);
            stalled = ov0 && !or0;
            prev_d  = od0;
            prev_s  = os0;
        end
    end

    `MON(m0, q0, ov0, or0, od0, os0, "d0")
    `MON(m1, q1, ov1, 1'b1, od1, os1, "d1")
    `MON(m2, q2, ov2, 1'b1, od2, os2, "d2")
    `MON(m3, q3, ov3, 1'b1, od3, os3, "n3")
    `MON(m4, q4, ov4, 1'b1, od4, os4, "n1")
    `MON(m5, q5, ov5, 1'b1, od5, os5, "n5")

    // Present one beat from posedge+1 until the main DUT accepts it.
    task automatic send(input logic [95:0] v, input logic last);
        int  n;
        logic ok;
        n   = 0;
        din = v;
        lin = last;
        vin = 1'b1;
        forever begin
            @(negedge clk);
            ok = rdy0;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 300) begin
                tfail("send timeout");
                break;
            end
        end
        vin = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()
                + q4.size() + q5.size()) != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) tfail("drain timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic push01(input exp_t a, input exp_t b);
        q0.push_back(a);
        q1.push_back(b);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          s;
        int          lat;
        logic        l;
        logic [95:0] v;

        #2;
        rst_n = 1'b0;
        #1;
        chk("reset out_valid d0", int'(ov0), 0);
        chk("reset out_data d0", int'(od0), 0);
        chk("reset out_sat d0", int'(os0), 0);
        chk("reset out_valid d2", int'(ov2), 0);
        chk("reset out_data d2", int'(od2), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after reset",
            int'({rdy0, rdy1, rdy2, rdy3, rdy4, rdy5}), 63);

        // Directed vectors, one beat per group on the accumulating DUT.
        push01(mk(127, 1), mk(-12, 1));
        q2.push_back(mk(1524, 0));
        send(fill(127), 1'b1);
        lat = 1;
        while (!ov0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency n12", lat, 5);

        push01(mk(-128, 1), mk(0, 1));
        q2.push_back(mk(-1536, 0));
        send(fill(-128), 1'b1);

        for (int j = 0; j < 12; j++) v[j*8 +: 8] = 8'(j + 1);
        push01(mk(78, 0), mk(78, 0));
        q2.push_back(mk(78, 0));
        send(v, 1'b1);

        // Accumulation groups back to back.
        push01(mk(12, 0), mk(12, 0));
        send(fill(1), 1'b0);
        push01(mk(24, 0), mk(24, 0));
        send(fill(2), 1'b0);
        push01(mk(36, 0), mk(36, 0));
        q2.push_back(mk(72, 0));
        send(fill(3), 1'b1);
        push01(mk(-12, 0), mk(-12, 0));
        send(fill(-1), 1'b0);
        push01(mk(-12, 0), mk(-12, 0));
        q2.push_back(mk(-24, 0));
        send(fill(-1), 1'b1);
        drain();

        // Backpressure stream with a model for expectations.
        rnd_or = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 12; j++) v[j*8 +: 8] = 8'($urandom_range(0, 255));
            l = (i % 4 == 3) || (i == 19);
            s = vsum(v, 12);
            push01(fitm(s, 8, 1'b1), fitm(s, 8, 1'b0));
            acc += s;
            if (l) begin
                q2.push_back(fitm(acc, 16, 1'b1));
                acc = 0;
            end
            send(v, l);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rnd_or = 1'b0;

        // Reset with beats in flight and a partial accumulation.
        en1 = 1'b0;
        or_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(fill(5), 1'b0);
        send(fill(5), 1'b0);
        send(fill(5), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("stalled out_valid", int'(ov0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async drop d0", int'(ov0), 0);
        chk("async drop d2", int'(ov2), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en1 = 1'b1;
        or_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push01(mk(24, 0), mk(24, 0));
        q2.push_back(mk(24, 0));
        send(fill(2), 1'b1);
        drain();

        // Odd and single-element trees.
        for (int j = 0; j < 12; j++) ds[j*8 +: 8] = 8'($urandom_range(0, 255));
        q3.push_back(fitm(vsum(ds, 3), 8, 1'b0));
        q4.push_back(fitm(vsum(ds, 1), 6, 1'b1));
        q5.push_back(fitm(vsum(ds, 5), 9, 1'b1));
        vs = 1'b1;
        @(posedge clk);
        #1;
        vs = 1'b0;
        lat = 1;
        while (!ov4 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency n1", lat, 2);
        drain();

        for (int i = 0; i < 1000; i++) begin
            vs = ($urandom_range(0, 4) != 0);
            for (int j = 0; j < 12; j++) ds[j*8 +: 8] = 8'($urandom_range(0, 255));
            if (vs) begin
                q3.push_back(fitm(vsum(ds, 3), 8, 1'b0));
                q4.push_back(fitm(vsum(ds, 1), 6, 1'b1));
                q5.push_back(fitm(vsum(ds, 5), 9, 1'b1));
            end
            @(posedge clk);
            #1;
        end
        vs = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
